// File: rtl/rggen_rtl_pkg.sv
// Shared definitions for the register-array blocks.
//   rggen_status          : access response code returned on o_status.
//   rggen_access_state_e  : access FSM states (idle / wait states / response).
//   rggen_index_width     : entry-index width for a given depth (minimum 1).
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    RGGEN_IDLE    = 2'b00,
    RGGEN_WAIT    = 2'b01,
    RGGEN_RESPOND = 2'b10
  } rggen_access_state_e;

  function automatic int rggen_index_width(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rggen_address_range_decoder.sv
// Word-address range decoder for a block of DEPTH consecutive entries.
//   i_address : byte address
//   o_select  : address falls inside [START_ADDRESS, START_ADDRESS + DEPTH words)
//   o_index   : entry index (word address minus start word address)
module rggen_address_range_decoder
  import rggen_rtl_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 16,
  parameter int                     DATA_WIDTH    = 32,
  parameter bit [ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
  parameter int                     DEPTH         = 4
)(
  input  logic [ADDRESS_WIDTH-1:0]            i_address,
  output logic                                o_select,
  output logic [rggen_index_width(DEPTH)-1:0] o_index
);

  localparam int IW    = rggen_index_width(DEPTH);
  localparam int SHIFT = $clog2(DATA_WIDTH / 8);

  // One extra bit so the subtraction borrow and the limit never wrap.
  localparam logic [ADDRESS_WIDTH:0] SADDR = {1'b0, START_ADDRESS >> SHIFT};
  localparam logic [ADDRESS_WIDTH:0] LIMIT = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic [ADDRESS_WIDTH:0] word_addr;
  logic [ADDRESS_WIDTH:0] offset;

  assign word_addr = {1'b0, i_address >> SHIFT};
  assign offset    = word_addr - SADDR;
  assign o_select  = (word_addr >= SADDR) && (offset < LIMIT);
  assign o_index   = offset[IW-1:0];

endmodule

// File: rtl/rggen_waited_register_array.sv
// Array of DEPTH identical registers behind a request/ready access port with
// a fixed number of wait states per access.
//   i_request/i_address/i_write/i_write_data/i_strobe : access request (held until o_ready)
//   o_select    : combinational address hit
//   o_ready     : one-cycle completion pulse, WAIT_CYCLES+1 cycles after acceptance
//   o_status    : OKAY, or SLAVE_ERROR when the access type has no implemented bits
//   o_read_data : read data, zero whenever o_ready is low
//   o_value     : all entries, entry n at [n*DATA_WIDTH +: DATA_WIDTH]
module rggen_waited_register_array
  import rggen_rtl_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 16,
  parameter bit [ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
  parameter int                     DATA_WIDTH    = 32,
  parameter int                     DEPTH         = 4,
  parameter bit [DATA_WIDTH-1:0]    VALID_BITS    = '1,
  parameter bit [DATA_WIDTH-1:0]    READABLE_BITS = '1,
  parameter bit [DATA_WIDTH-1:0]    WRITABLE_BITS = '1,
  parameter bit [DATA_WIDTH-1:0]    INITIAL_VALUE = '0,
  parameter int                     WAIT_CYCLES   = 0
)(
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_request,
  input  logic [ADDRESS_WIDTH-1:0]      i_address,
  input  logic                          i_write,
  input  logic [DATA_WIDTH-1:0]         i_write_data,
  input  logic [DATA_WIDTH/8-1:0]       i_strobe,
  output logic                          o_select,
  output logic                          o_ready,
  output logic [1:0]                    o_status,
  output logic [DATA_WIDTH-1:0]         o_read_data,
  output logic [DEPTH*DATA_WIDTH-1:0]   o_value
);

  localparam int IW = rggen_index_width(DEPTH);
  localparam int SW = DATA_WIDTH / 8;

  localparam logic [DATA_WIDTH-1:0] WR_MASK = WRITABLE_BITS & VALID_BITS;
  localparam logic [DATA_WIDTH-1:0] RD_MASK = READABLE_BITS & VALID_BITS;
  localparam logic [DATA_WIDTH-1:0] INIT    = INITIAL_VALUE & VALID_BITS;

  logic          select;
  logic [IW-1:0] index;

  rggen_address_range_decoder #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .START_ADDRESS (START_ADDRESS),
    .DEPTH         (DEPTH)
  ) u_decoder (
    .i_address (i_address),
    .o_select  (select),
    .o_index   (index)
  );

  assign o_select = select;

  rggen_access_state_e                  state_q,  state_d;
  logic [3:0]                           count_q,  count_d;
  logic [IW-1:0]                        index_q,  index_d;
  logic                                 write_q,  write_d;
  logic [DATA_WIDTH-1:0]                wdata_q,  wdata_d;
  logic [SW-1:0]                        strobe_q, strobe_d;
  logic                                 ready_q,  ready_d;
  rggen_status                          status_q, status_d;
  logic [DATA_WIDTH-1:0]                rdata_q,  rdata_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     value_q,  value_d;

  // With zero wait states the response is prepared in the accepting cycle,
  // before the access fields have been latched.
  logic [IW-1:0]         rsp_index;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] bit_en;

  assign rsp_index = (state_q == RGGEN_IDLE) ? index   : index_q;
  assign rsp_write = (state_q == RGGEN_IDLE) ? i_write : write_q;

  always_comb begin
    bit_en = '0;
    for (int b = 0; b < DATA_WIDTH; b++) bit_en[b] = strobe_q[b/8];
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    index_d  = index_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strobe_d = strobe_q;
    value_d  = value_q;
    ready_d  = 1'b0;
    status_d = RGGEN_OKAY;
    rdata_d  = '0;
    case (state_q)
      RGGEN_IDLE: begin
        if (i_request && select) begin
          index_d  = index;
          write_d  = i_write;
          wdata_d  = i_write_data;
          strobe_d = i_strobe;
          if (WAIT_CYCLES > 0) begin
            state_d = RGGEN_WAIT;
            count_d = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = RGGEN_RESPOND;
          end
        end
      end
      RGGEN_WAIT: begin
        if (count_q == 4'd0) state_d = RGGEN_RESPOND;
        else                 count_d = count_q - 4'd1;
      end
      RGGEN_RESPOND: begin
        state_d = RGGEN_IDLE;
        if (write_q && (WR_MASK != '0)) begin
          value_d[index_q] = (value_q[index_q] & ~(bit_en & WR_MASK))
                           | (wdata_q & bit_en & WR_MASK);
        end
      end
      default: state_d = RGGEN_IDLE;
    endcase

    // Response outputs are registered on entry to RESPOND.
    if (state_d == RGGEN_RESPOND && state_q != RGGEN_RESPOND) begin
      ready_d = 1'b1;
      if (rsp_write) begin
        if (WR_MASK == '0) status_d = RGGEN_SLAVE_ERROR;
      end else if (RD_MASK == '0) begin
        status_d = RGGEN_SLAVE_ERROR;
      end else begin
        rdata_d = value_q[rsp_index] & RD_MASK;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= RGGEN_IDLE;
      count_q  <= '0;
      index_q  <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strobe_q <= '0;
      ready_q  <= 1'b0;
      status_q <= RGGEN_OKAY;
      rdata_q  <= '0;
      value_q  <= {DEPTH{INIT}};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      index_q  <= index_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
      ready_q  <= ready_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      value_q  <= value_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_status    = status_q;
  assign o_read_data = rdata_q;
  assign o_value     = value_q;

endmodule
